reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-write scoreboard for the 5-stage ARM pipeline: the writer-side bookkeeping for the read-side hazard check done in ID. Tracks, per architectural register, how many issued instructions will still write it. Decides from that count whether the instruction currently in ID must stall, so hazard decisions no longer depend on comparing against individual EXE/MEM destination fields. Sits beside the ID stage: issue is fed from ID→EXE, retire from the WB stage.

## Interface
- NUM_REGS, 16, number of architectural registers tracked (R0–R15).
- CNT_W, 2, width of each per-register in-flight counter; maximum count is 2^CNT_W−1.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- issue_en  input  1  instruction leaves ID into EXE this cycle (already gated by stall/freeze/flush in the caller).
- issue_wb_en  input  1  issued instruction writes a register.
- issue_dest  input  4  destination register of the issued instruction.
- wb_en  input  1  WB stage writes the register file this cycle.
- wb_dest  input  4  register written by WB.
- src1  input  4  first source register of the instruction in ID.
- src2  input  4  second source register of the instruction in ID.
- two_src  input  1  src2 is a real operand.
- hazard_detected  output  1  combinational: instruction in ID must stall.
- pending_mask  output  NUM_REGS  registered: bit i set when count[i] ≠ 0.
- inflight_total  output  5  registered: sum of all counters.
- err  output  1  sticky: overflow or underflow occurred; cleared only by rst.

## Operation
- State: count[i], CNT_W bits, i = 0..NUM_REGS−1; err flag.
- inc = issue_en & issue_wb_en. dec = wb_en.
- Per-register next count:
  - inc to i, no dec to i: count+1.
  - dec to i, no inc to i: count−1.
  - inc and dec to same i in the same cycle: count unchanged.
  - Neither: unchanged.
- Overflow: inc to i with count[i] at max and no same-cycle dec to i. Count saturates at max, err set.
- Underflow: dec to i with count[i] = 0. Count stays 0, err set.
- busy(r) = count[r] ≠ 0, except when count[r] = 1 and wb_en & wb_dest = r in this cycle.
  - In that case busy(r) = 0, because the register file writes on the opposite edge and ID reads the new value.
- hazard_detected = busy(src1) | (two_src & busy(src2)) | full_dest.
  - full_dest = issue_wb_en & count[issue_dest] at max & ~(wb_en & wb_dest = issue_dest).
  - Note that issue_wb_en / issue_dest describe the instruction in ID.
- inflight_total is the registered sum of the next-state counters, so it matches pending_mask on the same cycle.
- Flushed instructions are never presented with issue_en, so they never increment.
- The caller must not assert issue_en while hazard_detected is high. If it does, counts still update per the rules above.

## Timing
- Reset (rst high at rising edge): all counts 0, pending_mask = 0, inflight_total = 0, err = 0. hazard_detected is then 0 for any inputs.
- rst overrides same-cycle issue/wb; the counters are reset regardless of activity in flight.
- Issue in cycle N: count visible, and hazard raised for a dependent src, from cycle N+1.
- Retire in cycle N: hazard for that register drops combinationally in cycle N when the count was 1. Count is 0 from N+1.
- Typical back-to-back dependency without forwarding: producer issues at N, retires at N+3. Dependent in ID stalls cycles N+1..N+2 and issues at N+3.
- No internal pipelining. hazard_detected is a combinational function of registered counts and the current inputs.

## Test plan
- Reset then idle: rst for 2 cycles, src1=3, two_src=1, src2=5 → hazard_detected=0, pending_mask=0x0000, inflight_total=0, err=0.
- Single RAW: issue dest=R2 at cycle 1; src1=R2 in cycles 2–4 with wb_en/wb_dest=R2 at cycle 4 → hazard=1 in cycles 2–3, hazard=0 in cycle 4, pending_mask=0x0000 at cycle 5.
- Double in-flight: issue R7 at cycles 1 and 2, retire R7 at cycle 4 → count 2 at cycle 3. Hazard on src1=R7 at cycle 4 stays 1 (count 2 ≠ 1). pending_mask bit7 stays 1 until the second retire.
- Simultaneous issue and retire to R4 with count 1 → count stays 1, inflight_total unchanged, err=0.
- Overflow: issue R1 four times with CNT_W=2 and no retire → count saturates at 3, err=1 and stays 1 until rst. full_dest drives hazard=1 while count=3 and issue_wb_en, issue_dest=R1.
- Underflow and two_src masking: wb_en to R9 with count 0 → err=1, count 0. Then src2=R9 busy with two_src=0 → hazard=0; with two_src=1 → hazard=1.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register in-flight writer counts drive the ID-stage
// stall decision. Issue increments, WB retire decrements, errors are sticky.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             ovf,
  output logic             unf
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_comb begin
    count_nxt = count;
    ovf       = 1'b0;
    unf       = dec && (count == '0);
    if (inc && !dec) begin
      if (count == MAX) ovf = 1'b1;
      else              count_nxt = count + CNT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end
endmodule

module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_en,
  input  logic                issue_wb_en,
  input  logic [3:0]          issue_dest,
  input  logic                wb_en,
  input  logic [3:0]          wb_dest,
  input  logic [3:0]          src1,
  input  logic [3:0]          src2,
  input  logic                two_src,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [4:0]          inflight_total,
  output logic                err
);
  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam int               SUM_W = $clog2(NUM_REGS * (2 ** CNT_W)) + 1;

  logic [NUM_REGS-1:0][CNT_W-1:0] count, count_nxt;
  logic [NUM_REGS-1:0]            inc_v, dec_v, ovf_v, unf_v, busy, nz_nxt;
  logic [SUM_W-1:0]               sum_nxt;
  logic                           inc, full_dest;

  assign inc = issue_en && issue_wb_en;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign inc_v[g] = inc && (issue_dest == 4'(g));
    assign dec_v[g] = wb_en && (wb_dest == 4'(g));

    reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_v[g]),
      .dec       (dec_v[g]),
      .count     (count[g]),
      .count_nxt (count_nxt[g]),
      .ovf       (ovf_v[g]),
      .unf       (unf_v[g])
    );

    // A last outstanding writer retiring now is not a hazard: the register
    // file writes on the opposite edge, so ID already sees the new value.
    assign busy[g]   = (count[g] != '0) && !((count[g] == ONE) && dec_v[g]);
    assign nz_nxt[g] = (count_nxt[g] != '0);
  end

  assign full_dest = issue_wb_en && (count[issue_dest] == MAX) &&
                     !(wb_en && (wb_dest == issue_dest));

  assign hazard_detected = busy[src1] || (two_src && busy[src2]) || full_dest;

  always_comb begin
    sum_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) sum_nxt = sum_nxt + SUM_W'(count_nxt[i]);
  end

  // Registered from next-state counts so mask and total line up with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_mask   <= '0;
      inflight_total <= '0;
      err            <= 1'b0;
    end else begin
      pending_mask   <= nz_nxt;
      inflight_total <= 5'(sum_nxt);
      err            <= err || (|ovf_v) || (|unf_v);
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-of-counts model.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst, issue_en, issue_wb_en, wb_en, two_src;
  logic [3:0]  issue_dest, wb_dest, src1, src2;
  logic        hazard_detected, err;
  logic [15:0] pending_mask;
  logic [4:0]  inflight_total;

  int checks = 0;
  int errors = 0;
  int m_cnt [16];
  bit m_err;
  bit last_hz;

  reg_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .wb_en(wb_en), .wb_dest(wb_dest), .src1(src1),
    .src2(src2), .two_src(two_src), .hazard_detected(hazard_detected),
    .pending_mask(pending_mask), .inflight_total(inflight_total), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int r);
    return m_cnt[r] != 0 && !(m_cnt[r] == 1 && wb_en && wb_dest == 4'(r));
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cyc(input bit ie, input bit iw, input int id, input bit we, input int wd,
                     input int s1, input int s2, input bit ts, input bit r);
    int mask, tot;
    bit exp_hz;
    rst = r; issue_en = ie; issue_wb_en = iw; issue_dest = 4'(id);
    wb_en = we; wb_dest = 4'(wd); src1 = 4'(s1); src2 = 4'(s2); two_src = ts;
    #2;
    mask = 0; tot = 0;
    for (int k = 0; k < 16; k++) begin
      if (m_cnt[k] != 0) mask |= (1 << k);
      tot += m_cnt[k];
    end
    exp_hz = m_busy(s1) || (ts && m_busy(s2)) ||
             (iw && m_cnt[id] == 3 && !(we && wd == id));
    last_hz = hazard_detected;
    check("hazard", int'(hazard_detected), int'(exp_hz));
    check("pending_mask", int'(pending_mask), mask);
    check("inflight_total", int'(inflight_total), tot % 32);
    check("err", int'(err), int'(m_err));
    if (r) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_err = 0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        bit i_k, d_k;
        i_k = ie && iw && id == k;
        d_k = we && wd == k;
        if (d_k && m_cnt[k] == 0) m_err = 1;
        if (i_k && !d_k) begin
          if (m_cnt[k] == 3) m_err = 1;
          else m_cnt[k]++;
        end else if (d_k && !i_k && m_cnt[k] != 0) m_cnt[k]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d);  cyc(1, 1, d, 0, 0, 0, 0, 0, 0); endtask
  task automatic retire(input int d); cyc(0, 0, 0, 1, d, 0, 0, 0, 0); endtask
  task automatic idle();              cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_err = 0;
    rst = 1; issue_en = 0; issue_wb_en = 0; issue_dest = 0;
    wb_en = 0; wb_dest = 0; src1 = 0; src2 = 0; two_src = 0;
    @(posedge clk); #1;
    // Reset then idle
    cyc(0, 0, 0, 0, 0, 3, 5, 1, 1);
    cyc(0, 0, 0, 0, 0, 3, 5, 1, 1);
    cyc(0, 0, 0, 0, 0, 3, 5, 1, 0);
    check("rst_hz", int'(last_hz), 0);
    check("rst_mask", int'(pending_mask), 0);
    check("rst_total", int'(inflight_total), 0);
    check("rst_err", int'(err), 0);
    // Single RAW on R2
    issue(2);
    cyc(0, 0, 0, 0, 0, 2, 0, 0, 0); check("raw_c2", int'(last_hz), 1);
    cyc(0, 0, 0, 0, 0, 2, 0, 0, 0); check("raw_c3", int'(last_hz), 1);
    cyc(0, 0, 0, 1, 2, 2, 0, 0, 0); check("raw_c4", int'(last_hz), 0);
    check("raw_mask", int'(pending_mask), 0);
    // Two writers of R7 in flight
    issue(7); issue(7);
    check("dbl_total", int'(inflight_total), 2);
    cyc(0, 0, 0, 1, 7, 7, 0, 0, 0); check("dbl_hz", int'(last_hz), 1);
    check("dbl_mask7", int'(pending_mask[7]), 1);
    check("dbl_total1", int'(inflight_total), 1);
    retire(7);
    check("dbl_mask0", int'(pending_mask), 0);
    // Simultaneous issue and retire of R4
    issue(4);
    cyc(1, 1, 4, 1, 4, 0, 0, 0, 0);
    check("sim_total", int'(inflight_total), 1);
    check("sim_err", int'(err), 0);
    retire(4);
    // Overflow on R1
    issue(1); issue(1); issue(1);
    check("ovf_total3", int'(inflight_total), 3);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0); check("full_dest_hz", int'(last_hz), 1);
    issue(1);
    check("ovf_err", int'(err), 1);
    check("ovf_sat", int'(inflight_total), 3);
    cyc(0, 1, 1, 1, 1, 0, 0, 0, 0); check("full_dest_wb", int'(last_hz), 0);
    idle();
    check("ovf_sticky", int'(err), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("err_clr", int'(err), 0);
    check("rst_total2", int'(inflight_total), 0);
    // Underflow and two_src masking on R9
    retire(9);
    check("unf_err", int'(err), 1);
    check("unf_total", int'(inflight_total), 0);
    issue(9);
    cyc(0, 0, 0, 0, 0, 0, 9, 0, 0); check("src2_masked", int'(last_hz), 0);
    cyc(0, 0, 0, 0, 0, 0, 9, 1, 0); check("src2_live", int'(last_hz), 1);
    // Reset overriding in-flight activity
    cyc(1, 1, 3, 1, 9, 0, 0, 0, 1);
    check("rst_over_mask", int'(pending_mask), 0);
    // Randomized traffic, low register range to force collisions
    for (int n = 0; n < 3000; n++) begin
      cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 5)), bit'($urandom_range(0, 2) == 0),
          int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 99) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
